// File: rtl/tb_stim_seq_if.sv
// Valid/ready word stream from the stimulus sequencer to the unit under test.
interface tb_stim_seq_if;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/tb_stim_seq.sv
// Stimulus sequencer: streams NUM_ITEMS CRC words, folds accepted words into a
// signature and reports done/pass against EXPECT_SUM.
module tb_stim_seq #(
    parameter int          NUM_ITEMS  = 10,
    parameter logic [63:0] SEED       = 64'h5aef0c8d_d70a4497,
    parameter logic [63:0] EXPECT_SUM = 64'h0,
    parameter bit          CHECK_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    tb_stim_seq_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [63:0]   sum,
    output logic [15:0]   count
);

    generate
        if (NUM_ITEMS > 65535 || NUM_ITEMS < 0) begin : g_num_items_range
            $error("tb_stim_seq: NUM_ITEMS must be within 0..65535");
        end
    endgenerate

    localparam logic [15:0] LAST  = 16'(NUM_ITEMS);
    localparam bit          EMPTY = (NUM_ITEMS == 0);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [63:0] crc, crc_nx, sum_nx, sum_step;
    logic [15:0] count_nx, count_inc;
    logic        pass_nx, hs;

    function automatic logic [63:0] crc_step(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[2] ^ v[0]};
    endfunction

    function automatic logic [63:0] sig_step(input logic [63:0] s, input logic [63:0] c);
        return c ^ crc_step(s);
    endfunction

    assign bus.out_valid = (state == RUN);
    assign bus.out_data  = crc;
    assign busy          = (state == RUN);
    assign done          = (state == DONE);

    always_comb begin
        state_nx  = state;
        crc_nx    = crc;
        sum_nx    = sum;
        count_nx  = count;
        pass_nx   = pass;
        hs        = (state == RUN) & bus.out_ready;
        count_inc = count + 16'd1;
        sum_step  = sig_step(sum, crc);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    crc_nx   = SEED;
                    sum_nx   = '0;
                    count_nx = '0;
                    // An empty run settles its verdict on the zero signature right away.
                    if (EMPTY) begin
                        state_nx = DONE;
                        pass_nx  = (EXPECT_SUM == 64'h0) | ~CHECK_EN;
                    end else begin
                        state_nx = RUN;
                        pass_nx  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (hs) begin
                    sum_nx   = sum_step;
                    crc_nx   = crc_step(crc);
                    count_nx = count_inc;
                    if (count_inc == LAST) begin
                        state_nx = DONE;
                        pass_nx  = (sum_step == EXPECT_SUM) | ~CHECK_EN;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            crc   <= SEED;
            sum   <= '0;
            count <= '0;
            pass  <= 1'b0;
        end else begin
            state <= state_nx;
            crc   <= crc_nx;
            sum   <= sum_nx;
            count <= count_nx;
            pass  <= pass_nx;
        end
    end

endmodule

// File: tb/tb_tb_stim_seq.sv
// Directed bench for tb_stim_seq: latency, throughput, stalls, pass variants,
// empty runs, mid-run reset and start-during-run.
module tb_tb_stim_seq;

    localparam logic [63:0] SEED = 64'h5aef0c8d_d70a4497;

    function automatic logic [63:0] lfsr(input logic [63:0] v);
        return {v[62:0], v[63] ^ v[2] ^ v[0]};
    endfunction

    function automatic logic [63:0] crc_at(input int k);
        logic [63:0] c;
        c = SEED;
        for (int i = 0; i < k; i++) c = lfsr(c);
        return c;
    endfunction

    function automatic logic [63:0] sum_after(input int n);
        logic [63:0] s, c;
        s = 64'h0;
        c = SEED;
        for (int i = 0; i < n; i++) begin
            s = c ^ lfsr(s);
            c = lfsr(c);
        end
        return s;
    endfunction

    localparam logic [63:0] GOLD = sum_after(10);

    logic clk = 1'b0;
    logic rst, start, ready;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    tb_stim_seq_if a_if ();
    tb_stim_seq_if b_if ();
    tb_stim_seq_if c_if ();
    tb_stim_seq_if d_if ();
    assign a_if.out_ready = ready;
    assign b_if.out_ready = ready;
    assign c_if.out_ready = ready;
    assign d_if.out_ready = ready;

    logic        a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic        c_busy, c_done, c_pass, d_busy, d_done, d_pass;
    logic [63:0] a_sum, b_sum, c_sum, d_sum;
    logic [15:0] a_count, b_count, c_count, d_count;

    // a: golden signature, b: one bit off, c: one bit off with checking disabled, d: empty run
    tb_stim_seq #(.EXPECT_SUM(GOLD)) u_a (
        .clk(clk), .rst(rst), .start(start), .bus(a_if),
        .busy(a_busy), .done(a_done), .pass(a_pass), .sum(a_sum), .count(a_count));
    tb_stim_seq #(.EXPECT_SUM(GOLD ^ 64'h1)) u_b (
        .clk(clk), .rst(rst), .start(start), .bus(b_if),
        .busy(b_busy), .done(b_done), .pass(b_pass), .sum(b_sum), .count(b_count));
    tb_stim_seq #(.EXPECT_SUM(GOLD ^ 64'h1), .CHECK_EN(1'b0)) u_c (
        .clk(clk), .rst(rst), .start(start), .bus(c_if),
        .busy(c_busy), .done(c_done), .pass(c_pass), .sum(c_sum), .count(c_count));
    tb_stim_seq #(.NUM_ITEMS(0)) u_d (
        .clk(clk), .rst(rst), .start(start), .bus(d_if),
        .busy(d_busy), .done(d_done), .pass(d_pass), .sum(d_sum), .count(d_count));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          vcnt, cyc, stalls;
        logic        was_ready;
        logic [63:0] p_data, p_sum;
        logic [15:0] p_count;

        rst = 1'b1; start = 1'b0; ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("reset_valid", 64'(a_if.out_valid), 64'd0);
        check("reset_busy",  64'(a_busy),  64'd0);
        check("reset_done",  64'(a_done),  64'd0);
        check("reset_pass",  64'(a_pass),  64'd0);
        check("reset_sum",   a_sum,        64'd0);
        check("reset_count", 64'(a_count), 64'd0);
        check("reset_data",  a_if.out_data, SEED);

        // Unstalled run
        start = 1'b1; tick(); start = 1'b0;
        check("first_valid", 64'(a_if.out_valid), 64'd1);
        check("first_data",  a_if.out_data, 64'h5aef0c8d_d70a4497);
        check("first_busy",  64'(a_busy), 64'd1);
        check("first_count", 64'(a_count), 64'd0);
        check("empty_done",  64'(d_done), 64'd1);
        check("empty_valid", 64'(d_if.out_valid), 64'd0);
        check("empty_sum",   d_sum, 64'd0);
        check("empty_count", 64'(d_count), 64'd0);
        check("empty_pass",  64'(d_pass), 64'd1);
        tick();
        check("second_data",  a_if.out_data, 64'hb5de191b_ae14892e);
        check("second_count", 64'(a_count), 64'd1);
        check("second_sum",   a_sum, 64'h5aef0c8d_d70a4497);
        vcnt = 1;
        cyc  = 0;
        while (!a_done && cyc < 40) begin
            if (a_if.out_valid) vcnt++;
            tick();
            cyc++;
        end
        check("run_words",    64'(vcnt), 64'd10);
        check("run_cycles",   64'(cyc), 64'd9);
        check("run_done",     64'(a_done), 64'd1);
        check("run_busy",     64'(a_busy), 64'd0);
        check("run_valid",    64'(a_if.out_valid), 64'd0);
        check("run_count",    64'(a_count), 64'd10);
        check("run_sum",      a_sum, GOLD);
        check("pass_golden",  64'(a_pass), 64'd1);
        check("pass_bitoff",  64'(b_pass), 64'd0);
        check("pass_nocheck", 64'(c_pass), 64'd1);
        tick();
        check("done_held",    64'(a_done), 64'd1);

        // Stalled run, ready pattern 1,0,0 repeating
        start = 1'b1; tick(); start = 1'b0;
        check("restart_done",  64'(a_done), 64'd0);
        check("restart_pass",  64'(a_pass), 64'd0);
        check("restart_valid", 64'(a_if.out_valid), 64'd1);
        cyc = 0;
        stalls = 0;
        while (!a_done && cyc < 60) begin
            ready     = (cyc % 3 == 0);
            was_ready = ready;
            p_data    = a_if.out_data;
            p_sum     = a_sum;
            p_count   = a_count;
            tick();
            if (!was_ready) begin
                stalls++;
                check("stall_valid", 64'(a_if.out_valid), 64'd1);
                check("stall_data",  a_if.out_data, p_data);
                check("stall_sum",   a_sum, p_sum);
                check("stall_count", 64'(a_count), 64'(p_count));
            end
            cyc++;
        end
        ready = 1'b1;
        check("stall_cycles", 64'(stalls), 64'd18);
        check("stall_done",   64'(a_done), 64'd1);
        check("stall_final",  a_sum, GOLD);
        check("stall_words",  64'(a_count), 64'd10);
        check("stall_pass",   64'(a_pass), 64'd1);

        // start during RUN, then reset after 4 handshakes
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        check("ignore_start_count", 64'(a_count), 64'd3);
        check("ignore_start_data",  a_if.out_data, crc_at(3));
        tick();
        check("pre_reset_count", 64'(a_count), 64'd4);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_valid", 64'(a_if.out_valid), 64'd0);
        check("midrst_busy",  64'(a_busy), 64'd0);
        check("midrst_done",  64'(a_done), 64'd0);
        check("midrst_pass",  64'(a_pass), 64'd0);
        check("midrst_sum",   a_sum, 64'd0);
        check("midrst_count", 64'(a_count), 64'd0);
        check("midrst_data",  a_if.out_data, SEED);
        tick();
        check("idle_hold_valid", 64'(a_if.out_valid), 64'd0);
        start = 1'b1; tick(); start = 1'b0;
        check("replay_data0", a_if.out_data, SEED);
        check("replay_valid", 64'(a_if.out_valid), 64'd1);
        tick();
        check("replay_data1", a_if.out_data, 64'hb5de191b_ae14892e);
        check("replay_count", 64'(a_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tb_stim_seq.md
Name: tb_stim_seq

Overview:
- Self-checking stimulus sequencer for regression benches. Sits directly upstream of the unit under test.
- On start, emits NUM_ITEMS pseudo-random 64-bit words over a valid/ready stream, generated by the team-standard CRC shift register.
- Folds every accepted word into a running signature. Raises done/pass so the bench top can print the finish banner and end simulation.
- NUM_ITEMS default matches the shared package localparam PARAM (10).

Parameters:
- NUM_ITEMS, 10, number of words to emit per run (0 allowed).
- SEED, 64'h5aef0c8d_d70a4497, CRC initial value loaded on start.
- EXPECT_SUM, 64'h0, golden signature compared at end of run.
- CHECK_EN, 1, when 0 pass is forced to 1 at done.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  single-cycle request to begin a run.
- out_valid  output  1  word on out_data is offered.
- out_ready  input  1  downstream accepts the word.
- out_data  output  64  current CRC word.
- busy  output  1  run in progress (RUN state).
- done  output  1  run complete; held high.
- pass  output  1  signature check result; valid only while done=1.
- sum  output  64  running signature.
- count  output  16  words accepted this run.

Behaviour:
- Reset (rst=1 at posedge), any state, including mid-run: state=IDLE; out_valid=0, busy=0, done=0, pass=0, sum=0, count=0, crc=SEED. out_data equals crc at all times.
- CRC step: crc_next = {crc[62:0], crc[63]^crc[2]^crc[0]}.
- Signature step: sum_next = crc ^ {sum[62:0], sum[63]^sum[2]^sum[0]}.
- States:
  - IDLE:
    - out_valid=0.
    - start=1 → load crc=SEED, sum=0, count=0.
    - Next state: RUN if NUM_ITEMS>0, else DONE (sum=0, count=0).
  - RUN:
    - busy=1, out_valid=1.
    - Handshake = out_valid & out_ready. On a handshake: sum←sum_next (using current crc), crc←crc_next, count←count+1.
    - If the handshake makes count reach NUM_ITEMS → DONE in the same edge.
    - start is ignored.
  - DONE:
    - out_valid=0, busy=0, done=1.
    - pass = (sum==EXPECT_SUM) | ~CHECK_EN, registered on DONE entry.
    - start=1 → restart as from IDLE (done and pass drop next cycle).
- Latency: first out_valid one cycle after the start cycle. out_valid is registered.
- Stall: while out_valid=1 and out_ready=0, out_data, sum and count are held stable. out_valid is never withdrawn until the word is accepted.
- Throughput: one word per cycle when out_ready is held high. A run of N words takes N cycles in RUN.
- out_ready is don't-care outside RUN.
- count is 16 bits; NUM_ITEMS must be ≤ 65535. This is a compile-time check that raises $error.

Test Plan:
- Reset, then start pulse with out_ready=1 → next cycle out_valid=1, out_data=64'h5aef0c8d_d70a4497; following cycle out_data=64'hb5de191b_ae14892e, count=1, sum=64'h5aef0c8d_d70a4497.
- out_ready=1 continuously, NUM_ITEMS=10 → exactly 10 handshakes in 10 consecutive cycles. Then done=1, busy=0, count=10, out_valid=0.
- out_ready toggled 1,0,0,1,… → out_data/sum/count frozen during the 0 cycles. Same final sum as the unstalled run.
- Set EXPECT_SUM to the final sum of the unstalled run → pass=1. EXPECT_SUM off by one bit → pass=0. CHECK_EN=0 with the wrong EXPECT_SUM → pass=1.
- NUM_ITEMS=0, start → DONE the next cycle, out_valid never asserted, sum=0, count=0.
- rst asserted after 4 handshakes → next cycle IDLE, all outputs 0. A new start replays the sequence from SEED. start asserted during RUN has no effect on count/crc.
